// File: rtl/tbec_encoder_pipe_if.sv
// rtl/tbec_encoder_pipe_if.sv - handshake bundle for the TBEC encoder pipeline
//
// Groups the input stream (in_valid/in_ready/in_data/inj_mask), the output
// stream (out_valid/out_ready/out_word) and the completed-word counter.
// master: the side that produces input words and consumes codewords.
// slave : the encoder itself.
interface tbec_encoder_pipe_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [31:0]      inj_mask;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic [CNT_W-1:0] word_count;

    modport master (
        output in_valid, in_data, inj_mask, out_ready,
        input  in_ready, out_valid, out_word, word_count
    );

    modport slave (
        input  in_valid, in_data, inj_mask, out_ready,
        output in_ready, out_valid, out_word, word_count
    );
endinterface

// File: rtl/tbec_encoder_pipe.sv
// rtl/tbec_encoder_pipe.sv - two-stage streaming TBEC encoder, 16-bit data to 32-bit codeword
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - tbec_encoder_pipe_if.slave: input stream, output stream, word_count
// Parameters:
//   CNT_W  - width of the wrapping output-handshake counter
//   INJ_EN - 1: inj_mask is XORed into the codeword, 0: mask ignored
module tbec_encoder_pipe #(
    parameter int CNT_W  = 16,
    parameter bit INJ_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    tbec_encoder_pipe_if.slave  bus
);

    // Codeword: [31:16] data, [15:12] DI1,DI4,DI2,DI3, [11:8] P1,P4,P2,P3,
    // [7:0] XA_1_3,XA_2_4,XB_1_3,XB_2_4,XC_1_3,XC_2_4,XD_1_3,XD_2_4.
    function automatic logic [31:0] tbec_encode(input logic [15:0] data);
        logic a1, b1, c1, d1, a2, b2, c2, d2;
        logic a3, b3, c3, d3, a4, b4, c4, d4;
        logic [3:0] di, p;
        logic [7:0] x;
        {a1, b1, c1, d1, a2, b2, c2, d2, a3, b3, c3, d3, a4, b4, c4, d4} = data;
        di = {a1 ^ b2 ^ c1 ^ d2,    // DI1
              a4 ^ b3 ^ c4 ^ d3,    // DI4
              a2 ^ b1 ^ c2 ^ d1,    // DI2
              a3 ^ b4 ^ c3 ^ d4};   // DI3
        p  = {a1 ^ a2 ^ b1 ^ b2,    // P1
              c3 ^ c4 ^ d3 ^ d4,    // P4
              c1 ^ c2 ^ d1 ^ d2,    // P2
              a3 ^ a4 ^ b3 ^ b4};   // P3
        x  = {a1 ^ a3, a2 ^ a4, b1 ^ b3, b2 ^ b4,
              c1 ^ c3, c2 ^ c4, d1 ^ d3, d2 ^ d4};
        return {data, di, p, x};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_data_q,  s1_data_d;
    logic [31:0]      s1_mask_q,  s1_mask_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_word_q,  s2_word_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic s2_adv;
    logic s1_adv;

    // A stage may load when it is empty or when the stage after it drains
    // this cycle; this chaining gives one word per cycle with no bubble.
    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mask_d  = s1_mask_q;
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        cnt_d      = cnt_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = bus.in_data;
                s1_mask_d = bus.inj_mask;
            end
        end

        // An empty S1 shifting forward leaves out_word untouched; only the
        // valid flag drops.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_word_d = tbec_encode(s1_data_q) ^ (INJ_EN ? s1_mask_q : 32'h0);
            end
        end

        if (s2_valid_q && bus.out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mask_q  <= s1_mask_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready   = s1_adv && !rst;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_word   = s2_word_q;
    assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_tbec_encoder_pipe.sv
// tb/tb_tbec_encoder_pipe.sv - self-checking bench for tbec_encoder_pipe
module tb_tbec_encoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tbec_encoder_pipe_if #(.CNT_W(16)) bus   ();
    tbec_encoder_pipe_if #(.CNT_W(16)) bus_c ();
    tbec_encoder_pipe_if #(.CNT_W(4))  bus_w ();

    // The clean and narrow-counter instances see exactly the main stimulus.
    assign bus_c.in_valid  = bus.in_valid;
    assign bus_c.in_data   = bus.in_data;
    assign bus_c.inj_mask  = bus.inj_mask;
    assign bus_c.out_ready = bus.out_ready;
    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.in_data   = bus.in_data;
    assign bus_w.inj_mask  = bus.inj_mask;
    assign bus_w.out_ready = bus.out_ready;

    tbec_encoder_pipe #(.CNT_W(16), .INJ_EN(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus));
    tbec_encoder_pipe #(.CNT_W(16), .INJ_EN(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
    tbec_encoder_pipe #(.CNT_W(4),  .INJ_EN(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: recompute every check bit from the data half and
    // flag any disagreement with the stored check half.
    function automatic void tbec_decode(input logic [31:0] cw, output logic [15:0] data,
                                        output logic [1:0] err);
        logic [3:0] a, b, c, dd;
        logic [15:0] chk;
        data = cw[31:16];
        for (int g = 0; g < 4; g++) begin
            a[g]  = data[15 - 4*g];
            b[g]  = data[14 - 4*g];
            c[g]  = data[13 - 4*g];
            dd[g] = data[12 - 4*g];
        end
        chk[15] = a[0] ^ b[1] ^ c[0] ^ dd[1];
        chk[14] = a[3] ^ b[2] ^ c[3] ^ dd[2];
        chk[13] = a[1] ^ b[0] ^ c[1] ^ dd[0];
        chk[12] = a[2] ^ b[3] ^ c[2] ^ dd[3];
        chk[11] = a[0] ^ a[1] ^ b[0] ^ b[1];
        chk[10] = c[2] ^ c[3] ^ dd[2] ^ dd[3];
        chk[9]  = c[0] ^ c[1] ^ dd[0] ^ dd[1];
        chk[8]  = a[2] ^ a[3] ^ b[2] ^ b[3];
        chk[7]  = a[0] ^ a[2];
        chk[6]  = a[1] ^ a[3];
        chk[5]  = b[0] ^ b[2];
        chk[4]  = b[1] ^ b[3];
        chk[3]  = c[0] ^ c[2];
        chk[2]  = c[1] ^ c[3];
        chk[1]  = dd[0] ^ dd[2];
        chk[0]  = dd[1] ^ dd[3];
        err = (chk == cw[15:0]) ? 2'b00 : 2'b01;
    endfunction

    typedef struct {
        logic [15:0] data;
        logic [31:0] mask;
        logic [31:0] exp_inj;
        logic [31:0] exp_clean;
    } vec_t;

    localparam int NV = 7;
    vec_t v [NV];

    logic [15:0] sd [6];
    logic [31:0] se [6];

    initial begin
        int sent;
        int got;
        int n_in;
        int n_out;
        logic [31:0] prev;
        logic [15:0] q [$];
        logic [15:0] dec_data;
        logic [1:0]  dec_err;
        logic [15:0] exp_d;

        v[0] = '{16'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        v[1] = '{16'h8000, 32'h0000_0000, 32'h8000_8880, 32'h8000_8880};
        v[2] = '{16'h0001, 32'h0000_0000, 32'h0001_1401, 32'h0001_1401};
        v[3] = '{16'hFFFF, 32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
        v[4] = '{16'h8000, 32'h0000_0001, 32'h8000_8881, 32'h8000_8880};
        v[5] = '{16'h1234, 32'h0000_0000, 32'h1234_411C, 32'h1234_411C};
        v[6] = '{16'h0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000};

        sd = '{16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000, 16'h8000};
        se = '{32'h8000_8880, 32'h0001_1401, 32'hFFFF_0000, 32'h1234_411C,
               32'h0000_0000, 32'h8000_8880};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inj_mask  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready",   32'(bus.in_ready),    32'h0);
        check("rst_out_valid",  32'(bus.out_valid),   32'h0);
        check("rst_out_word",   bus.out_word,         32'h0);
        check("rst_word_count", 32'(bus.word_count),  32'h0);
        check("rst_w4_count",   32'(bus_w.word_count), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Table vectors, back to back, two-cycle latency
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                bus.in_valid = 1'b1;
                bus.in_data  = v[i].data;
                bus.inj_mask = v[i].mask;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (i < NV) check("b2b_in_ready", 32'(bus.in_ready), 32'h1);
            tick();
            if (i == 0) begin
                check("latency_not_early", 32'(bus.out_valid), 32'h0);
            end else begin
                check("vec_out_valid", 32'(bus.out_valid), 32'h1);
                check("vec_inj_word",  bus.out_word,   v[i-1].exp_inj);
                check("vec_clean_word", bus_c.out_word, v[i-1].exp_clean);
            end
        end
        tick();
        check("vec_drained",    32'(bus.out_valid),    32'h0);
        check("vec_word_count", 32'(bus.word_count),   32'(NV));
        check("vec_w4_count",   32'(bus_w.word_count), 32'(NV % 16));

        // Six-word stream with a three-cycle output stall
        sent = 0;
        got  = 0;
        prev = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            bus.in_valid  = (sent < 6);
            bus.in_data   = (sent < 6) ? sd[sent] : 16'h0;
            bus.inj_mask  = '0;
            bus.out_ready = !(c >= 2 && c <= 4);
            #1;
            if (c >= 2 && c <= 4) begin
                check("stall_in_ready",  32'(bus.in_ready),  32'h0);
                check("stall_out_valid", 32'(bus.out_valid), 32'h1);
                if (c > 2) check("stall_hold_word", bus.out_word, prev);
            end
            prev = bus.out_word;
            if (bus.out_valid && bus.out_ready) begin
                check("stall_order", bus.out_word, se[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stall_all_out",    32'(got), 32'h6);
        check("stall_word_count", 32'(bus.word_count), 32'(NV + 6));

        // Asynchronous reset with two words in flight
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8000;
        tick();
        bus.in_data  = 16'h0001;
        tick();
        bus.in_valid = 1'b0;
        #2;
        check("inflight_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("async_out_valid",  32'(bus.out_valid),  32'h0);
        check("async_out_word",   bus.out_word,        32'h0);
        check("async_word_count", 32'(bus.word_count), 32'h0);
        check("async_in_ready",   32'(bus.in_ready),   32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_stale_word", 32'(bus.out_valid), 32'h0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("first_after_rst_valid", 32'(bus.out_valid), 32'h1);
        check("first_after_rst_word",  bus.out_word,       32'hFFFF_0000);
        tick();
        check("first_after_rst_count", 32'(bus.word_count), 32'h1);

        // Counter wrap on the 4-bit instance
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int k = 0; k < 17; k++) tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("wrap_w4_count",   32'(bus_w.word_count), 32'h1);
        check("wrap_main_count", 32'(bus.word_count),   32'd17);

        // Random stream through the reference decoder, random backpressure
        rst = 1'b1;
        #1;
        rst = 1'b0;
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
            bus.in_valid  = (n_in < 10000) && ($urandom_range(0, 9) < 8);
            bus.in_data   = 16'($urandom);
            bus.inj_mask  = '0;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_word", bus.out_word, 32'h0 ^ ~bus.out_word);
                end else begin
                    exp_d = q.pop_front();
                    tbec_decode(bus.out_word, dec_data, dec_err);
                    check("rand_decoded_data", 32'(dec_data), 32'(exp_d));
                    check("rand_error_code",   32'(dec_err),  32'h0);
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                n_in++;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_complete",   32'(n_out), 32'd10000);
        check("rand_queue_empty", 32'(q.size()), 32'h0);
        check("rand_word_count", 32'(bus.word_count), 32'd10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
